// File: rtl/tx_sequencer.sv
// Byte transmit sequencer: fetches message bytes from a synchronous RAM and presents
// them to a modulator with valid/ready handshaking. Define TX_PREAMBLE_EN to add a preamble.
module tx_sequencer #(
  parameter int          MAX_LEN       = 1000,
  parameter int          PREAMBLE_LEN  = 4,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'h55
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_transmit,
  input  logic [9:0] i_msg_length,
  output logic       o_ram_rd,
  output logic [9:0] o_ram_addr,
  input  logic [7:0] i_ram_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic       o_busy,
  output logic       o_tx_done
);

`ifdef TX_PREAMBLE_EN
  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_FETCH, S_WAIT, S_PRESENT, S_DONE
  } state_t;
  localparam int PW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [PW-1:0] L_PRE_LAST = PW'(PREAMBLE_LEN - 1);
  logic [PW-1:0] r_pre_cnt;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_PRESENT, S_DONE
  } state_t;
`endif

  localparam logic [9:0] L_MAX = 10'(MAX_LEN);

  state_t     r_state;
  logic       r_transmit;
  logic [9:0] r_idx;
  logic [9:0] r_len;

  logic       w_start;
  logic [9:0] w_len_clamp;
  logic [9:0] w_idx_next;
  logic       w_more;

  assign w_start     = i_transmit & ~r_transmit;
  assign w_len_clamp = (i_msg_length > L_MAX) ? L_MAX : i_msg_length;
  assign w_idx_next  = r_idx + 10'd1;
  assign w_more      = (w_idx_next < r_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_transmit   <= 1'b0;
      r_idx        <= 10'd0;
      r_len        <= 10'd0;
      o_byte       <= 8'h00;
      o_byte_valid <= 1'b0;
      o_ram_rd     <= 1'b0;
      o_ram_addr   <= 10'd0;
      o_busy       <= 1'b0;
      o_tx_done    <= 1'b0;
`ifdef TX_PREAMBLE_EN
      r_pre_cnt    <= '0;
`endif
    end else begin
      r_transmit <= i_transmit;
      o_ram_rd   <= 1'b0;
      o_tx_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Edges arriving in any other state fall through untouched.
          if (w_start) begin
            r_len  <= w_len_clamp;
            r_idx  <= 10'd0;
            o_busy <= 1'b1;
`ifdef TX_PREAMBLE_EN
            r_pre_cnt    <= '0;
            o_byte       <= PREAMBLE_BYTE;
            o_byte_valid <= 1'b1;
            r_state      <= S_PREAMBLE;
`else
            if (w_len_clamp != 10'd0) begin
              o_ram_rd   <= 1'b1;
              o_ram_addr <= 10'd0;
              r_state    <= S_FETCH;
            end else begin
              o_tx_done <= 1'b1;
              r_state   <= S_DONE;
            end
`endif
          end
        end
`ifdef TX_PREAMBLE_EN
        S_PREAMBLE: begin
          if (i_byte_ready) begin
            if (r_pre_cnt == L_PRE_LAST) begin
              o_byte_valid <= 1'b0;
              if (r_len != 10'd0) begin
                o_ram_rd   <= 1'b1;
                o_ram_addr <= 10'd0;
                r_state    <= S_FETCH;
              end else begin
                o_tx_done <= 1'b1;
                r_state   <= S_DONE;
              end
            end else begin
              r_pre_cnt <= r_pre_cnt + 1'b1;
            end
          end
        end
`endif
        S_FETCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          o_byte       <= i_ram_data;
          o_byte_valid <= 1'b1;
          r_state      <= S_PRESENT;
        end
        S_PRESENT: begin
          if (i_byte_ready) begin
            o_byte_valid <= 1'b0;
            // idx only advances when another byte follows, so it never passes len-1.
            if (w_more) begin
              r_idx      <= w_idx_next;
              o_ram_addr <= w_idx_next;
              o_ram_rd   <= 1'b1;
              r_state    <= S_FETCH;
            end else begin
              o_tx_done <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_idx   <= 10'd0;
          r_state <= S_IDLE;
        end
        default: begin
          o_busy       <= 1'b0;
          o_byte_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_sequencer.sv
// Directed self-checking bench for tx_sequencer with a synchronous RAM model and
// a handshake monitor; preamble expectations follow TX_PREAMBLE_EN.
module tb_tx_sequencer;

`ifdef TX_PREAMBLE_EN
  localparam int NPRE = 4;
`else
  localparam int NPRE = 0;
`endif
  localparam int FIRST_LAT = (NPRE > 0) ? 1 : 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_transmit;
  logic [9:0] i_msg_length;
  logic       o_ram_rd;
  logic [9:0] o_ram_addr;
  logic [7:0] i_ram_data;
  logic [7:0] o_byte;
  logic       o_byte_valid;
  logic       i_byte_ready;
  logic       o_busy;
  logic       o_tx_done;

  int checks = 0;
  int failures = 0;

  tx_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .i_transmit   (i_transmit),
    .i_msg_length (i_msg_length),
    .o_ram_rd     (o_ram_rd),
    .o_ram_addr   (o_ram_addr),
    .i_ram_data   (i_ram_data),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .i_byte_ready (i_byte_ready),
    .o_busy       (o_busy),
    .o_tx_done    (o_tx_done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data appears the cycle after the read strobe.
  logic [7:0] mem [0:1023];
  logic [7:0] ram_q = 8'h00;
  always @(posedge clk) if (o_ram_rd) ram_q <= mem[o_ram_addr];
  assign i_ram_data = ram_q;

  // Monitor: logs accepted bytes, RAM reads and done pulses.
  int         cyc = 0;
  int         rd_cnt = 0;
  int         done_cnt = 0;
  int         last_acc_cyc = -1;
  logic [7:0] acc_q[$];
  logic [9:0] addr_q[$];
  always @(posedge clk) begin
    cyc++;
    if (o_byte_valid && i_byte_ready) begin
      acc_q.push_back(o_byte);
      last_acc_cyc = cyc;
    end
    if (o_ram_rd) begin
      rd_cnt++;
      addr_q.push_back(o_ram_addr);
    end
    if (o_tx_done) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    reset = 1'b1; i_transmit = 1'b0; i_msg_length = 10'd0; i_byte_ready = 1'b0;
    repeat (3) tick();
    obs = {o_ram_rd, o_ram_addr, o_byte, o_byte_valid, o_busy, o_tx_done};
    checks++;
    if (obs !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", obs);
    end
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (o_busy !== 1'b0 || rd_cnt !== 0) begin
      failures++;
      $display("FAIL reset_idle busy=%b rd=%0d want busy=0 rd=0", o_busy, rd_cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int base_acc, base_rd, base_done, first_k, done_k, bad;
    bit done_aligned;
    logic [7:0] exp_q[$];
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
    i_byte_ready = 1'b1; i_msg_length = 10'd3;
    base_acc = acc_q.size(); base_rd = rd_cnt; base_done = done_cnt;
    first_k = -1; done_k = -1; done_aligned = 1'b0;
    i_transmit = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (o_byte_valid && first_k < 0) first_k = k;
      if (o_tx_done) begin
        done_k = k;
        done_aligned = (cyc == last_acc_cyc);
        break;
      end
    end
    checks++;
    if (first_k !== FIRST_LAT) begin
      failures++;
      $display("FAIL basic_first_latency got=%0d want=%0d", first_k, FIRST_LAT);
    end
    checks++;
    if (done_k !== FIRST_LAT + 7 + 4 * (NPRE > 0 ? 1 : 0) - (NPRE > 0 ? 0 : 0) + ((NPRE > 0) ? 2 : 0)) begin
      failures++;
      $display("FAIL basic_done_time got=%0d want=%0d", done_k, (NPRE > 0) ? 14 : 10);
    end
    checks++;
    if (!done_aligned) begin
      failures++;
      $display("FAIL basic_done_after_accept cyc=%0d last_accept=%0d", cyc, last_acc_cyc);
    end
    for (int i = 0; i < NPRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
    bad = 0;
    if (acc_q.size() != base_acc + exp_q.size()) bad++;
    else for (int i = 0; i < exp_q.size(); i++) if (acc_q[base_acc + i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL basic_bytes count=%0d want=%0d bad=%0d", acc_q.size() - base_acc, exp_q.size(), bad);
    end
    tick();
    checks++;
    if (o_tx_done !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse done=%b busy=%b want 0 0", o_tx_done, o_busy);
    end
    repeat (10) tick();
    checks++;
    if (rd_cnt != base_rd + 3 || done_cnt != base_done + 1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_no_restart rd=%0d done=%0d busy=%b want rd=3 done=1 busy=0",
               rd_cnt - base_rd, done_cnt - base_done, o_busy);
    end
    i_transmit = 1'b0;
    tick();
    $display("test_basic done first=%0d done_at=%0d", first_k, done_k);
  endtask

  task automatic test_zero_len();
    int base_acc, base_rd, done_k, valid_ticks;
    i_byte_ready = 1'b1; i_msg_length = 10'd0;
    base_acc = acc_q.size(); base_rd = rd_cnt;
    done_k = -1; valid_ticks = 0;
    i_transmit = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (o_byte_valid) valid_ticks++;
      if (o_tx_done) begin
        done_k = k;
        break;
      end
    end
    checks++;
    if (done_k !== NPRE + 1) begin
      failures++;
      $display("FAIL zero_done_time got=%0d want=%0d", done_k, NPRE + 1);
    end
    checks++;
    if (rd_cnt != base_rd || valid_ticks != NPRE || acc_q.size() != base_acc + NPRE) begin
      failures++;
      $display("FAIL zero_no_data rd=%0d valid=%0d acc=%0d want rd=0 valid=%0d acc=%0d",
               rd_cnt - base_rd, valid_ticks, acc_q.size() - base_acc, NPRE, NPRE);
    end
    tick();
    checks++;
    if (o_tx_done !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_done_pulse done=%b busy=%b want 0 0", o_tx_done, o_busy);
    end
    i_transmit = 1'b0;
    tick();
    $display("test_zero_len done done_at=%0d", done_k);
  endtask

  task automatic test_backpressure();
    int base_acc, base_rd, hold_rd, bad, waited;
    logic [7:0] exp_first;
    logic [7:0] exp_q[$];
    mem[0] = 8'h11; mem[1] = 8'h22;
    i_byte_ready = 1'b0; i_msg_length = 10'd2;
    base_acc = acc_q.size(); base_rd = rd_cnt;
    exp_first = (NPRE > 0) ? 8'h55 : 8'h11;
    i_transmit = 1'b1;
    waited = 0;
    while (!o_byte_valid && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (o_byte_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_valid_timeout valid=%b want=1", o_byte_valid);
    end
    i_transmit = 1'b0;
    hold_rd = rd_cnt;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (o_byte_valid !== 1'b1 || o_byte !== exp_first) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold_stable bad=%0d byte=%h want=%h valid=%b", bad, o_byte, exp_first, o_byte_valid);
    end
    checks++;
    if (rd_cnt != hold_rd) begin
      failures++;
      $display("FAIL bp_no_extra_rd got=%0d want=%0d", rd_cnt - base_rd, hold_rd - base_rd);
    end
    i_byte_ready = 1'b1;
    waited = 0;
    while (!o_tx_done && waited < 60) begin
      tick();
      waited++;
    end
    for (int i = 0; i < NPRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    bad = 0;
    if (acc_q.size() != base_acc + exp_q.size()) bad++;
    else for (int i = 0; i < exp_q.size(); i++) if (acc_q[base_acc + i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || o_tx_done !== 1'b1 || rd_cnt != base_rd + 2) begin
      failures++;
      $display("FAIL bp_message bad=%0d done=%b rd=%0d want bad=0 done=1 rd=2", bad, o_tx_done, rd_cnt - base_rd);
    end
    repeat (2) tick();
    $display("test_backpressure done");
  endtask

  task automatic test_clamp();
    int base_acc, base_rd, base_done, bad, waited;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    i_byte_ready = 1'b1; i_msg_length = 10'd1023;
    base_acc = acc_q.size(); base_rd = rd_cnt; base_done = done_cnt;
    i_transmit = 1'b1;
    repeat (10) tick();
    // Length change and a fresh edge mid-message must both be ignored.
    i_msg_length = 10'd5;
    i_transmit = 1'b0;
    tick();
    i_transmit = 1'b1;
    waited = 0;
    while (!o_tx_done && waited < 3200) begin
      tick();
      waited++;
    end
    checks++;
    if (o_tx_done !== 1'b1) begin
      failures++;
      $display("FAIL clamp_done_timeout done=%b want=1", o_tx_done);
    end
    bad = 0;
    if (acc_q.size() != base_acc + NPRE + 1000) bad++;
    else for (int i = 0; i < 1000; i++) if (acc_q[base_acc + NPRE + i] !== (8'(i) ^ 8'h5A)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clamp_bytes count=%0d want=%0d bad=%0d", acc_q.size() - base_acc, NPRE + 1000, bad);
    end
    checks++;
    if (rd_cnt != base_rd + 1000 || addr_q[addr_q.size() - 1] !== 10'd999 || addr_q[base_rd] !== 10'd0) begin
      failures++;
      $display("FAIL clamp_reads rd=%0d last_addr=%0d want rd=1000 last_addr=999",
               rd_cnt - base_rd, addr_q[addr_q.size() - 1]);
    end
    repeat (6) tick();
    checks++;
    if (done_cnt != base_done + 1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL clamp_single_msg done=%0d busy=%b want done=1 busy=0", done_cnt - base_done, o_busy);
    end
    i_transmit = 1'b0;
    tick();
    $display("test_clamp done bytes=%0d", acc_q.size() - base_acc);
  endtask

  task automatic test_reset_mid();
    int base_acc, base_done, base_rd, bad, waited;
    logic [22:0] obs;
    logic [7:0] exp_q[$];
    for (int i = 0; i < 5; i++) mem[i] = 8'hD0 + 8'(i);
    i_byte_ready = 1'b1; i_msg_length = 10'd5;
    base_acc = acc_q.size(); base_done = done_cnt;
    i_transmit = 1'b1;
    waited = 0;
    while (acc_q.size() < base_acc + NPRE + 2 && waited < 60) begin
      tick();
      waited++;
    end
    reset = 1'b1;
    #1;
    obs = {o_ram_rd, o_ram_addr, o_byte, o_byte_valid, o_busy, o_tx_done};
    checks++;
    if (obs !== 23'd0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%h want=0", obs);
    end
    repeat (2) tick();
    checks++;
    if (done_cnt != base_done) begin
      failures++;
      $display("FAIL rstmid_no_done got=%0d want=0", done_cnt - base_done);
    end
    base_acc = acc_q.size(); base_rd = rd_cnt;
    reset = 1'b0;
    waited = 0;
    while (!o_tx_done && waited < 80) begin
      tick();
      waited++;
    end
    for (int i = 0; i < NPRE; i++) exp_q.push_back(8'h55);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'hD0 + 8'(i));
    bad = 0;
    if (acc_q.size() != base_acc + exp_q.size()) bad++;
    else for (int i = 0; i < exp_q.size(); i++) if (acc_q[base_acc + i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || o_tx_done !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_resend bad=%0d done=%b count=%0d want bad=0 done=1 count=%0d",
               bad, o_tx_done, acc_q.size() - base_acc, exp_q.size());
    end
    checks++;
    if (rd_cnt != base_rd + 5 || addr_q[base_rd] !== 10'd0) begin
      failures++;
      $display("FAIL rstmid_addr rd=%0d first_addr=%0d want rd=5 first_addr=0",
               rd_cnt - base_rd, addr_q[base_rd]);
    end
    i_transmit = 1'b0;
    repeat (2) tick();
    $display("test_reset_mid done");
  endtask

  initial begin
    reset = 1'b1; i_transmit = 1'b0; i_msg_length = 10'd0; i_byte_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_clamp();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
